// File: rtl/kbest_path_select.sv
// K-best back end: two-level min-PED tournament over the four survivors,
// followed by a credit-protected output FIFO tagging each decision with a vector index.
`ifndef ERR_WL
`define ERR_WL 16
`endif

module kbest_path_select #(
    parameter int N     = 8,
    parameter int DEPTH = 4,
    parameter int IDX_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*N*2-1:0]        PATH_in,
    input  logic [4*`ERR_WL-1:0]    PED_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N*2-1:0]          SYM_out,
    output logic [`ERR_WL-1:0]      PED_min,
    output logic [IDX_W-1:0]        vec_idx,
    output logic                    sat_flag
);

    localparam int PW = N * 2;
    localparam int EW = `ERR_WL;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    // Strict less-than: on equal PEDs the first (lower-index) candidate keeps the slot.
    function automatic logic second_wins(input logic [EW-1:0] first, input logic [EW-1:0] second);
        return (second < first);
    endfunction

    function automatic logic is_saturated(input logic [EW-1:0] ped);
        return (&ped);
    endfunction

    logic [EW-1:0]    ped_in_s  [4];
    logic [PW-1:0]    path_in_s [4];
    logic             accept_s;
    logic             s1a_sel_s, s1b_sel_s, s2_sel_s;
    logic [PW-1:0]    s1a_path_s, s1b_path_s, s2_path_s;
    logic [EW-1:0]    s1a_ped_s, s1b_ped_s, s2_ped_s;

    logic [IDX_W-1:0] idx_cnt_r;
    logic             s1_valid_r;
    logic [IDX_W-1:0] s1_idx_r;
    logic [PW-1:0]    s1a_path_r, s1b_path_r;
    logic [EW-1:0]    s1a_ped_r, s1b_ped_r;

    logic             s2_valid_r;
    logic [IDX_W-1:0] s2_idx_r;
    logic [PW-1:0]    s2_path_r;
    logic [EW-1:0]    s2_ped_r;
    logic             s2_sat_r;

    logic [PW-1:0]    mem_path_r [DEPTH];
    logic [EW-1:0]    mem_ped_r  [DEPTH];
    logic [IDX_W-1:0] mem_idx_r  [DEPTH];
    logic             mem_sat_r  [DEPTH];
    logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_s, pop_s;
    logic [CW:0]      credit_s;

    // Slice the packed survivor bus into per-path views.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            ped_in_s[k]  = PED_in[k*EW +: EW];
            path_in_s[k] = PATH_in[k*PW +: PW];
        end
    end

    // Credits count every entry that is buffered or still in flight, so the FIFO cannot overflow.
    assign credit_s  = {1'b0, count_r} + {{CW{1'b0}}, s1_valid_r} + {{CW{1'b0}}, s2_valid_r};
    assign in_ready  = (credit_s < DEPTH_C);
    assign accept_s  = in_valid && in_ready;
    assign out_valid = (count_r != {CW{1'b0}});
    assign push_s    = s2_valid_r;
    assign pop_s     = out_valid && out_ready;

    // First tournament level: pair (0,1) and pair (2,3).
    always_comb begin
        s1a_sel_s = second_wins(ped_in_s[0], ped_in_s[1]);
        s1b_sel_s = second_wins(ped_in_s[2], ped_in_s[3]);
        if (s1a_sel_s) begin
            s1a_path_s = path_in_s[1];
            s1a_ped_s  = ped_in_s[1];
        end else begin
            s1a_path_s = path_in_s[0];
            s1a_ped_s  = ped_in_s[0];
        end
        if (s1b_sel_s) begin
            s1b_path_s = path_in_s[3];
            s1b_ped_s  = ped_in_s[3];
        end else begin
            s1b_path_s = path_in_s[2];
            s1b_ped_s  = ped_in_s[2];
        end
    end

    // Final tournament level between the two pair winners.
    always_comb begin
        s2_sel_s = second_wins(s1a_ped_r, s1b_ped_r);
        if (s2_sel_s) begin
            s2_path_s = s1b_path_r;
            s2_ped_s  = s1b_ped_r;
        end else begin
            s2_path_s = s1a_path_r;
            s2_ped_s  = s1a_ped_r;
        end
    end

    // Index counter and the two non-stalling pipeline stages.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_cnt_r  <= {IDX_W{1'b0}};
            s1_valid_r <= 1'b0;
            s1_idx_r   <= {IDX_W{1'b0}};
            s1a_path_r <= {PW{1'b0}};
            s1b_path_r <= {PW{1'b0}};
            s1a_ped_r  <= {EW{1'b0}};
            s1b_ped_r  <= {EW{1'b0}};
            s2_valid_r <= 1'b0;
            s2_idx_r   <= {IDX_W{1'b0}};
            s2_path_r  <= {PW{1'b0}};
            s2_ped_r   <= {EW{1'b0}};
            s2_sat_r   <= 1'b0;
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                idx_cnt_r  <= idx_cnt_r + IDX_W'(1);
                s1_idx_r   <= idx_cnt_r;
                s1a_path_r <= s1a_path_s;
                s1b_path_r <= s1b_path_s;
                s1a_ped_r  <= s1a_ped_s;
                s1b_ped_r  <= s1b_ped_s;
            end
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_idx_r  <= s1_idx_r;
                s2_path_r <= s2_path_s;
                s2_ped_r  <= s2_ped_s;
                s2_sat_r  <= is_saturated(s2_ped_s);
            end
        end
    end

    // Output FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_path_r[i] <= {PW{1'b0}};
                mem_ped_r[i]  <= {EW{1'b0}};
                mem_idx_r[i]  <= {IDX_W{1'b0}};
                mem_sat_r[i]  <= 1'b0;
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_path_r[wr_ptr_r] <= s2_path_r;
                mem_ped_r[wr_ptr_r]  <= s2_ped_r;
                mem_idx_r[wr_ptr_r]  <= s2_idx_r;
                mem_sat_r[wr_ptr_r]  <= s2_sat_r;
                wr_ptr_r             <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign SYM_out  = mem_path_r[rd_ptr_r];
    assign PED_min  = mem_ped_r[rd_ptr_r];
    assign vec_idx  = mem_idx_r[rd_ptr_r];
    assign sat_flag = mem_sat_r[rd_ptr_r];

endmodule

// File: tb/tb_kbest_path_select.sv
// Self-checking bench for kbest_path_select: vector table plus scoreboard queue,
// with hand-written latency, backpressure, streaming and mid-stream reset sequences.
`ifndef ERR_WL
`define ERR_WL 16
`endif

module tb_kbest_path_select;

    localparam int N     = 8;
    localparam int DEPTH = 4;
    localparam int IDX_W = 8;
    localparam int PW    = N * 2;
    localparam int EW    = `ERR_WL;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [4*PW-1:0]      PATH_in;
    logic [4*EW-1:0]      PED_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [PW-1:0]        SYM_out;
    logic [EW-1:0]        PED_min;
    logic [IDX_W-1:0]     vec_idx;
    logic                 sat_flag;

    kbest_path_select #(.N(N), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .PATH_in(PATH_in), .PED_in(PED_in), .out_valid(out_valid), .out_ready(out_ready),
        .SYM_out(SYM_out), .PED_min(PED_min), .vec_idx(vec_idx), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PW-1:0]    sym;
        logic [EW-1:0]    ped;
        logic [IDX_W-1:0] idx;
        logic             sat;
    } exp_t;

    typedef struct packed {
        logic [4*EW-1:0] peds;
        logic [4*PW-1:0] paths;
        logic [PW-1:0]   sym;
        logic [EW-1:0]   ped;
        logic            sat;
    } vec_t;

    exp_t             sb_q[$];
    vec_t             tbl [7];
    int               n_cmp  = 0;
    int               n_fail = 0;
    int               out_cnt = 0;
    int               stall_cnt = 0;
    logic [IDX_W-1:0] exp_idx = '0;
    logic [63:0]      p0, p1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack4(input logic [15:0] a0, input logic [15:0] a1,
                                          input logic [15:0] a2, input logic [15:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic vec_t mk(input logic [4*EW-1:0] peds, input logic [4*PW-1:0] paths,
                                input logic [PW-1:0] sym, input logic [EW-1:0] ped, input logic sat);
        vec_t v;
        v.peds = peds; v.paths = paths; v.sym = sym; v.ped = ped; v.sat = sat;
        return v;
    endfunction

    // Reference: linear scan keeping the first strictly smaller PED.
    function automatic vec_t model(input logic [4*EW-1:0] peds, input logic [4*PW-1:0] paths);
        vec_t v;
        int   best = 0;
        for (int k = 1; k < 4; k++)
            if (peds[k*EW +: EW] < peds[best*EW +: EW]) best = k;
        v.peds  = peds;
        v.paths = paths;
        v.sym   = paths[best*PW +: PW];
        v.ped   = peds[best*EW +: EW];
        v.sat   = (v.ped == {EW{1'b1}});
        return v;
    endfunction

    function automatic vec_t rand_vec();
        logic [4*EW-1:0] peds;
        logic [4*PW-1:0] paths;
        for (int k = 0; k < 4; k++) begin
            peds[k*EW +: EW]  = EW'($urandom_range(0, 15));
            paths[k*PW +: PW] = PW'($urandom);
        end
        return model(peds, paths);
    endfunction

    // Scoreboard consumer: every handshake on the output pops and compares one entry.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && out_valid && out_ready) begin
            out_cnt++;
            if (sb_q.size() == 0) begin
                check("spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("sym",     64'(SYM_out),  64'(e.sym));
                check("ped_min", 64'(PED_min),  64'(e.ped));
                check("vec_idx", 64'(vec_idx),  64'(e.idx));
                check("sat",     64'(sat_flag), 64'(e.sat));
            end
        end
    end

    task automatic send(input vec_t v);
        int t = 0;
        exp_t e;
        in_valid = 1'b1;
        PED_in   = v.peds;
        PATH_in  = v.paths;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            stall_cnt++;
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 64'(in_ready), 64'd1);
        end else begin
            e.sym = v.sym; e.ped = v.ped; e.idx = exp_idx; e.sat = v.sat;
            sb_q.push_back(e);
            exp_idx = exp_idx + IDX_W'(1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb_q.size() != 0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb_q.delete();
        exp_idx = '0;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int          acc;
        int          o0;
        vec_t        v;
        logic [PW-1:0] held_sym;

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; PATH_in = '0; PED_in = '0;
        p0 = pack4(16'h1111, 16'hA5A5, 16'h2222, 16'h4444);
        p1 = pack4(16'h0F0F, 16'h3C3C, 16'hC3C3, 16'hF0F0);
        tbl[0] = mk(pack4(16'd40, 16'd12, 16'd33, 16'd90), p0, 16'hA5A5, 16'd12, 1'b0);
        tbl[1] = mk(pack4(16'd7, 16'd7, 16'd7, 16'd7), p1, 16'h0F0F, 16'd7, 1'b0);
        tbl[2] = mk(pack4(16'd9, 16'd5, 16'd5, 16'd9), p0, 16'hA5A5, 16'd5, 1'b0);
        tbl[3] = mk(pack4(16'd100, 16'd200, 16'd3, 16'd3), p1, 16'hC3C3, 16'd3, 1'b0);
        tbl[4] = mk(pack4(16'd50, 16'd60, 16'd70, 16'd20), p0, 16'h4444, 16'd20, 1'b0);
        tbl[5] = mk(pack4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), p1, 16'h0F0F, 16'hFFFF, 1'b1);
        tbl[6] = mk(pack4(16'hFFFF, 16'hFFFE, 16'hFFFF, 16'hFFFF), p1, 16'h3C3C, 16'hFFFE, 1'b0);

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sym",       64'(SYM_out),   64'd0);
        check("rst_ped_min",   64'(PED_min),   64'd0);
        check("rst_vec_idx",   64'(vec_idx),   64'd0);
        check("rst_sat",       64'(sat_flag),  64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Single vector latency: out_valid after the third edge, for one cycle.
        out_ready = 1'b1;
        send(tbl[0]);
        check("lat_e0", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_e1", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_e2", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        check("lat_e3", 64'(out_valid), 64'd0);

        // Remaining table vectors back to back: ties, saturation, near-saturation.
        for (int i = 1; i < 7; i++) send(tbl[i]);
        drain();

        // Backpressure: in_valid held, downstream stalled.
        do_reset();
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            v = rand_vec();
            in_valid = 1'b1;
            PED_in   = v.peds;
            PATH_in  = v.paths;
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back({v.sym, v.ped, exp_idx, v.sat});
                exp_idx = exp_idx + IDX_W'(1);
                acc++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("bp_accepts",      64'(acc),       64'd4);
        check("bp_in_ready_low", 64'(in_ready),  64'd0);
        check("bp_out_valid",    64'(out_valid), 64'd1);
        check("bp_head_idx",     64'(vec_idx),   64'd0);
        check("bp_head_sym",     64'(SYM_out),   64'(sb_q[0].sym));
        held_sym = SYM_out;
        repeat (2) @(posedge clk);
        #1;
        check("bp_head_stable", 64'(SYM_out), 64'(held_sym));
        o0 = out_cnt;
        out_ready = 1'b1;
        #1;
        check("bp_no_same_cycle_credit", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        check("bp_in_ready_back", 64'(in_ready), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        check("bp_outputs", 64'(out_cnt - o0), 64'd4);
        drain();

        // Streaming 300 vectors: no stalls, one output per cycle, index wraps.
        do_reset();
        out_ready = 1'b1;
        o0 = out_cnt;
        stall_cnt = 0;
        for (int i = 0; i < 300; i++) send(rand_vec());
        check("stream_pipelined", 64'(out_cnt - o0), 64'd297);
        repeat (3) @(posedge clk);
        #1;
        check("stream_total",  64'(out_cnt - o0), 64'd300);
        check("stream_stalls", 64'(stall_cnt),    64'd0);
        drain();

        // Mid-stream reset with two entries buffered and two in flight.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(rand_vec());
        check("mrst_full", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("mrst_out_valid", 64'(out_valid), 64'd0);
        check("mrst_vec_idx",   64'(vec_idx),   64'd0);
        sb_q.delete();
        exp_idx = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        o0 = out_cnt;
        repeat (6) @(posedge clk);
        #1;
        check("mrst_no_stale", 64'(out_cnt - o0), 64'd0);
        send(rand_vec());
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
